// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    // req_op is one-hot {mult, multu, div, divu}
    localparam int MDU_OP_W = 4;
    localparam int OP_MULT  = 3;
    localparam int OP_MULTU = 2;
    localparam int OP_DIV   = 1;
    localparam int OP_DIVU  = 0;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> multiply/divide unit bundle: request, operands, stall and hi/lo result.
// Latency: n/a (wires only).
// Backpressure: ex_hold from the pipeline, stallreq_for_ex towards IF..EX.
// master = EX stage side, slave = mdu_ctrl.
interface mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    import mdu_ctrl_pkg::*;

    logic                req_valid;
    logic [MDU_OP_W-1:0] req_op;
    logic [WIDTH-1:0]    src_a;
    logic [WIDTH-1:0]    src_b;
    logic                flush;
    logic                ex_hold;
    logic                stallreq_for_ex;
    logic                busy;
    logic                hilo_we;
    logic [WIDTH-1:0]    hi_out;
    logic [WIDTH-1:0]    lo_out;

    modport master (
        output req_valid, req_op, src_a, src_b, flush, ex_hold,
        input  stallreq_for_ex, busy, hilo_we, hi_out, lo_out
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush, ex_hold,
        output stallreq_for_ex, busy, hilo_we, hi_out, lo_out
    );

endinterface

// File: rtl/mdu_iter_core.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_nxt.
// Ports: is_div selects divide; acc = {upper, lower} working register;
//        operand = multiplicand (mult) or divisor (div); acc_nxt = stepped value.
module mdu_iter_core
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // multiply: acc = {partial product, multiplier}; add when LSB set, keep carry, shift right
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // divide: acc = {remainder, dividend/quotient}; shift left one bit into remainder
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, operand};
        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Sequencer for MULT/MULTU/DIV/DIVU: latches |a|,|b|, iterates ITER cycles, sign-fixes into hi/lo.
// Latency: accept at T, result registered entering DONE at T+ITER+1; stall asserted T..T+ITER.
// Backpressure: ex_hold keeps DONE (and hilo_we) held; flush aborts to IDLE from any state.
// Ports: clk, resetn (async active-low), bus (slave side of mdu_ctrl_if).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_ctrl_if.slave  bus
);

    localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mdu_state_t          state, state_nxt;
    logic [CW-1:0]       count;
    logic [2*WIDTH-1:0]  acc, acc_nxt, prod;
    logic [WIDTH-1:0]    operand, dividend;
    logic [WIDTH-1:0]    hi_q, lo_q, hi_fix, lo_fix;
    logic                is_div, neg_lo, neg_hi, div0;
    logic                op_ok, start, last_iter;
    logic                sgn, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]    mag_a, mag_b;
    logic                stall, busy_o, we_o;

    assign op_ok     = $onehot(bus.req_op);
    assign start     = bus.req_valid && !bus.flush && op_ok;
    assign last_iter = (count == LAST);

    assign sgn    = bus.req_op[OP_MULT] | bus.req_op[OP_DIV];
    assign op_div = bus.req_op[OP_DIV]  | bus.req_op[OP_DIVU];
    assign a_neg  = sgn & bus.src_a[WIDTH-1];
    assign b_neg  = sgn & bus.src_b[WIDTH-1];
    // most-negative input negates to itself, which is the correct unsigned magnitude
    assign mag_a  = a_neg ? -bus.src_a : bus.src_a;
    assign mag_b  = b_neg ? -bus.src_b : bus.src_b;

    mdu_iter_core #(.WIDTH(WIDTH)) u_iter (
        .is_div  (is_div),
        .acc     (acc),
        .operand (operand),
        .acc_nxt (acc_nxt)
    );

    // sign fix applied to the final step so results land in hi/lo on entering DONE
    always_comb begin
        prod   = neg_lo ? -acc_nxt : acc_nxt;
        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                lo_fix = '1;
                hi_fix = dividend;
            end else begin
                lo_fix = neg_lo ? -acc_nxt[WIDTH-1:0]       : acc_nxt[WIDTH-1:0];
                hi_fix = neg_hi ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        busy_o    = (state != MDU_IDLE);
        we_o      = 1'b0;
        case (state)
            MDU_IDLE: begin
                // malformed op encodings are ignored: no start, no stall
                stall = bus.req_valid && op_ok && !bus.flush;
                if (start) state_nxt = MDU_BUSY;
            end
            MDU_BUSY: begin
                stall = bus.req_valid && !bus.flush;
                if (bus.flush)      state_nxt = MDU_IDLE;
                else if (last_iter) state_nxt = MDU_DONE;
            end
            MDU_DONE: begin
                we_o = !bus.flush;
                if (bus.flush || !bus.ex_hold) state_nxt = MDU_IDLE;
            end
            default: state_nxt = MDU_IDLE;
        endcase
        // keep the pipeline free while reset is asserted
        if (!resetn) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            dividend <= '0;
            is_div   <= 1'b0;
            div0     <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        acc      <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                        operand  <= op_div ? mag_b : mag_a;
                        dividend <= bus.src_a;
                        is_div   <= op_div;
                        div0     <= op_div && (bus.src_b == '0);
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= op_div ? a_neg : (a_neg ^ b_neg);
                        count    <= '0;
                    end
                end
                MDU_BUSY: begin
                    acc   <= acc_nxt;
                    count <= count + 1'b1;
                    if (last_iter && !bus.flush) begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stallreq_for_ex = stall;
    assign bus.busy            = busy_o;
    assign bus.hilo_we         = we_o;
    assign bus.hi_out          = hi_q;
    assign bus.lo_out          = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus randomized ops against an arithmetic model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mdu_ctrl;

    localparam int W    = 32;
    localparam int ITER = 32;

    localparam logic [3:0] OPC_MULT  = 4'b1000;
    localparam logic [3:0] OPC_MULTU = 4'b0100;
    localparam logic [3:0] OPC_DIV   = 4'b0010;
    localparam logic [3:0] OPC_DIVU  = 4'b0001;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mdu_ctrl_if #(.WIDTH(W)) bus();

    mdu_ctrl #(.WIDTH(W), .ITER(ITER)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int          n_vec  = 0;
    int          n_err  = 0;
    int          we_cnt = 0;
    int          we_exp = 0;
    logic [63:0] last_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            OPC_MULT:  p = 64'(sa * sb);
            OPC_MULTU: p = {32'b0, a} * {32'b0, b};
            OPC_DIV, OPC_DIVU: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = (op == OPC_DIV) ? sa / sb : ua / ub;
                    r = (op == OPC_DIV) ? sa % sb : ua % ub;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = 'x;
        endcase
        return p;
    endfunction

    // count write strobes well away from both edges
    always @(negedge clk) begin
        #2;
        if (resetn && bus.hilo_we) we_cnt++;
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [63:0] exp;
        int          cyc, stalls;
        logic        moved;
        exp = ref_result(op, a, b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.ex_hold   = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check({tag, "_idle_at_accept"}, {63'b0, bus.busy}, 64'd0);
        cyc = 0; stalls = 0; moved = 1'b0;
        while (!bus.hilo_we && cyc < 200) begin
            if (bus.stallreq_for_ex) stalls++;
            if ({bus.hi_out, bus.lo_out} !== last_res) moved = 1'b1;
            @(negedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(ITER + 1));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(ITER + 1));
        check({tag, "_hilo_held_while_busy"}, {63'b0, moved}, 64'd0);
        check({tag, "_result"}, {bus.hi_out, bus.lo_out}, exp);
        check({tag, "_no_stall_in_done"}, {63'b0, bus.stallreq_for_ex}, 64'd0);
        for (int k = 0; k < hold; k++) begin
            bus.ex_hold = 1'b1;
            @(negedge clk); #1;
            check({tag, "_held_we"}, {63'b0, bus.hilo_we}, 64'd1);
            check({tag, "_held_result"}, {bus.hi_out, bus.lo_out}, exp);
        end
        bus.ex_hold = 1'b0;
        we_exp += 1 + hold;
        last_res = exp;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0;
        #1;
        check("idle_busy", {63'b0, bus.busy}, 64'd0);
        check("idle_we", {63'b0, bus.hilo_we}, 64'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        bus.ex_hold   = 1'b0;
        last_res      = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        check("reset_flags", {61'b0, bus.busy, bus.hilo_we, bus.stallreq_for_ex}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_op(OPC_MULT,  32'hFFFF_FFFD, 32'd5, 0, "mult_neg3x5");
        do_op(OPC_MULTU, 32'hFFFF_FFFF, 32'd2, 0, "multu_max_x2");
        go_idle();
        do_op(OPC_DIV,   32'hFFFF_FFF9, 32'd2, 0, "div_neg7_2");
        do_op(OPC_DIVU,  32'h8000_0000, 32'd3, 0, "divu_min_3");
        do_op(OPC_DIVU,  32'd7, 32'd0, 0, "divu_by_zero");
        do_op(OPC_MULT,  32'd2, 32'd3, 0, "mult_2x3");
        do_op(OPC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_neg1");
        do_op(OPC_MULT,  32'h1234_5678, 32'h8000_0000, 3, "mult_ex_hold");
        go_idle();

        // malformed op encodings must be ignored
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b0000;
        #1;
        check("bad_op_zero_stall", {63'b0, bus.stallreq_for_ex}, 64'd0);
        @(negedge clk);
        bus.req_op = 4'b0011;
        #1;
        check("bad_op_multi_stall", {63'b0, bus.stallreq_for_ex}, 64'd0);
        check("bad_op_multi_busy", {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        #1;
        check("bad_op_still_idle", {63'b0, bus.busy}, 64'd0);
        go_idle();

        // flush while BUSY with count == 10
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OPC_MULTU;
        bus.src_a     = 32'd9;
        bus.src_b     = 32'd9;
        repeat (11) @(negedge clk);
        #1;
        check("flush_pre_busy", {63'b0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        #1;
        check("flush_stall_drop", {63'b0, bus.stallreq_for_ex}, 64'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("flush_to_idle", {63'b0, bus.busy}, 64'd0);
        check("flush_hilo_kept", {bus.hi_out, bus.lo_out}, last_res);
        repeat (40) @(negedge clk);
        check("flush_no_we", 64'(we_cnt), 64'(we_exp));

        for (int i = 0; i < 16; i++) begin
            op = 4'b0001 << $urandom_range(0, 3);
            a  = pick_val();
            b  = pick_val();
            do_op(op, a, b, $urandom_range(0, 2), "rand");
            if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OPC_DIV;
        bus.src_a     = 32'd100;
        bus.src_b     = 32'd7;
        repeat (6) @(negedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_mid_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        check("rst_mid_flags", {61'b0, bus.busy, bus.hilo_we, bus.stallreq_for_ex}, 64'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("rst_mid_no_we_after", {63'b0, bus.hilo_we}, 64'd0);
        check("we_total", 64'(we_cnt), 64'(we_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
